// File: rtl/gomoku_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gomoku_pkg
// Brief    : Shared cell codes, game-result codes, board size default and
//            the controller FSM encoding for the stone-placement path.
// Revision : 1.0  initial release
// ============================================================================
package gomoku_pkg;

    // Default cells per row/column
    localparam int c_BOARD_DIM = 15;

    // Cell contents as held in the board store
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Game result codes
    localparam logic [1:0] ST_PLAY = 2'b00;
    localparam logic [1:0] ST_BWIN = 2'b01;
    localparam logic [1:0] ST_WWIN = 2'b10;
    localparam logic [1:0] ST_DRAW = 2'b11;

    // Controller FSM encoding
    localparam int         c_FSM_W    = 3;
    localparam logic [2:0] FSM_CLEAR  = 3'd0;
    localparam logic [2:0] FSM_IDLE   = 3'd1;
    localparam logic [2:0] FSM_LOOKUP = 3'd2;
    localparam logic [2:0] FSM_WRITE  = 3'd3;
    localparam logic [2:0] FSM_CHECK  = 3'd4;
    localparam logic [2:0] FSM_OVER   = 3'd5;
    localparam logic [2:0] FSM_UNDO   = 3'd6;

    // Stone code for the side to move (0 black, 1 white)
    function automatic logic [1:0] player_cell(input logic player);
        return player ? CELL_WHITE : CELL_BLACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_store.sv
`default_nettype none
// ============================================================================
// Module   : board_store
// Brief    : DEPTH x 2-bit board register array. One synchronous write port,
//            two combinational read ports. No reset: the owner clears it.
//            Reads beyond the last cell return empty.
// Revision : 1.0  initial release
// ============================================================================
module board_store #(
    parameter int DEPTH  = 225,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [1:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [1:0]        o_rd_data,
    input  logic [ADDR_W-1:0] i_lk_addr,
    output logic [1:0]        o_lk_data
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0] r_mem [DEPTH];

    // Single write port; out-of-range writes are discarded
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr <= c_LAST)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous reads for the checker/display and for the internal lookup
    always_comb begin
        o_rd_data = (i_rd_addr <= c_LAST) ? r_mem[i_rd_addr] : 2'b00;
        o_lk_data = (i_lk_addr <= c_LAST) ? r_mem[i_lk_addr] : 2'b00;
    end

endmodule
`default_nettype wire

// File: rtl/move_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_commit_ctrl
// Brief    : Validates a place request against the board, commits the stone,
//            hands the move to the win checker via req/done, and tracks the
//            side to move and the game result. Owns the board store.
//            Optional feature macro: UNDO_EN (one-level undo in IDLE).
// Revision : 1.0  initial release
// ============================================================================
module move_commit_ctrl
    import gomoku_pkg::*;
#(
    parameter int BOARD_DIM = c_BOARD_DIM,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_place,
    input  logic              i_new_game,
`ifdef UNDO_EN
    input  logic              i_undo,
`endif
    input  logic [ADDR_W-1:0] i_cur_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [1:0]        o_rd_data,
    output logic              o_chk_req,
    output logic [ADDR_W-1:0] o_chk_addr,
    output logic              o_chk_player,
    input  logic              i_chk_done,
    input  logic              i_chk_win,
    output logic              o_player,
    output logic [1:0]        o_state,
    output logic              o_busy,
    output logic              o_move_rej
);

    localparam int                c_CELLS     = BOARD_DIM * BOARD_DIM;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_CELLS - 1);
    localparam logic [CNT_W-1:0]  c_FULL      = CNT_W'(c_CELLS);

    logic [c_FSM_W-1:0] r_fsm;
    logic [c_FSM_W-1:0] w_fsm_nxt;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_player;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_chk_req;
    logic [ADDR_W-1:0]  r_chk_addr;
    logic               r_chk_player;
    logic               r_move_rej;

    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [1:0]         w_wdata;
    logic [1:0]         w_lk_data;
    logic               w_cell_free;
    logic               w_busy;

`ifdef UNDO_EN
    logic [ADDR_W-1:0]  r_last_addr;
    logic               r_last_vld;
`endif

    board_store #(
        .DEPTH  (c_CELLS),
        .ADDR_W (ADDR_W)
    ) u_board (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .i_lk_addr (r_addr),
        .o_lk_data (w_lk_data)
    );

    // Out-of-range cursor addresses count as occupied
    assign w_cell_free = (r_addr <= c_LAST_ADDR) && (w_lk_data == CELL_EMPTY);

    // FSM state register; reset parks in CLEAR so the board is wiped on release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= FSM_CLEAR;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state logic; new_game overrides every state and any place request
    always_comb begin
        w_fsm_nxt = r_fsm;
        if (i_new_game) begin
            w_fsm_nxt = FSM_CLEAR;
        end else begin
            case (r_fsm)
                FSM_CLEAR:  if (r_clr_addr == c_LAST_ADDR) w_fsm_nxt = FSM_IDLE;
                FSM_IDLE: begin
                    if (i_place) begin
                        w_fsm_nxt = FSM_LOOKUP;
                    end
`ifdef UNDO_EN
                    else if (i_undo && r_last_vld) begin
                        w_fsm_nxt = FSM_UNDO;
                    end
`endif
                end
                FSM_LOOKUP: w_fsm_nxt = w_cell_free ? FSM_WRITE : FSM_IDLE;
                FSM_WRITE:  w_fsm_nxt = FSM_CHECK;
                FSM_CHECK: begin
                    if (i_chk_done) begin
                        w_fsm_nxt = (i_chk_win || (r_cnt == c_FULL)) ? FSM_OVER : FSM_IDLE;
                    end
                end
                FSM_OVER:   w_fsm_nxt = FSM_OVER;
                FSM_UNDO:   w_fsm_nxt = FSM_IDLE;
                default:    w_fsm_nxt = FSM_CLEAR;
            endcase
        end
    end

    // Per-state outputs: board write port and busy flag
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = CELL_EMPTY;
        w_busy  = (r_fsm != FSM_IDLE) && (r_fsm != FSM_OVER);
        case (r_fsm)
            FSM_CLEAR: w_we = 1'b1;
            FSM_WRITE: begin
                w_we    = 1'b1;
                w_waddr = r_addr;
                w_wdata = player_cell(r_player);
            end
`ifdef UNDO_EN
            FSM_UNDO: begin
                w_we    = 1'b1;
                w_waddr = r_last_addr;
            end
`endif
            default: ;
        endcase
    end

    // Move datapath: address latch, turn, result, move count and checker handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_addr   <= '0;
            r_addr       <= '0;
            r_player     <= 1'b0;
            r_state      <= ST_PLAY;
            r_cnt        <= '0;
            r_chk_req    <= 1'b0;
            r_chk_addr   <= '0;
            r_chk_player <= 1'b0;
            r_move_rej   <= 1'b0;
        end else begin
            r_move_rej <= 1'b0;
            if (i_new_game) begin
                r_clr_addr <= '0;
                r_player   <= 1'b0;
                r_state    <= ST_PLAY;
                r_cnt      <= '0;
                r_chk_req  <= 1'b0;
            end else begin
                case (r_fsm)
                    FSM_CLEAR: begin
                        // Wrap to zero on the last cell so the next CLEAR starts clean
                        r_clr_addr <= (r_clr_addr == c_LAST_ADDR) ? '0 : r_clr_addr + 1'b1;
                    end
                    FSM_IDLE: begin
                        if (i_place) begin
                            r_addr <= i_cur_addr;
                        end
                    end
                    FSM_LOOKUP: begin
                        if (!w_cell_free) begin
                            r_move_rej <= 1'b1;
                        end
                    end
                    FSM_WRITE: begin
                        r_cnt        <= r_cnt + 1'b1;
                        r_chk_req    <= 1'b1;
                        r_chk_addr   <= r_addr;
                        r_chk_player <= r_player;
                    end
                    FSM_CHECK: begin
                        if (i_chk_done) begin
                            r_chk_req <= 1'b0;
                            if (i_chk_win) begin
                                r_state <= r_player ? ST_WWIN : ST_BWIN;
                            end else if (r_cnt == c_FULL) begin
                                r_state <= ST_DRAW;
                            end else begin
                                r_player <= ~r_player;
                            end
                        end
                    end
`ifdef UNDO_EN
                    FSM_UNDO: begin
                        // The committed move already flipped the turn; flip it back
                        r_player <= ~r_player;
                        r_cnt    <= r_cnt - 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef UNDO_EN
    // Last committed move, usable for exactly one undo
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
        end else if (i_new_game) begin
            r_last_vld <= 1'b0;
        end else if (r_fsm == FSM_WRITE) begin
            r_last_addr <= r_addr;
            r_last_vld  <= 1'b1;
        end else if (r_fsm == FSM_UNDO) begin
            r_last_vld <= 1'b0;
        end
    end
`endif

    assign o_chk_req    = r_chk_req;
    assign o_chk_addr   = r_chk_addr;
    assign o_chk_player = r_chk_player;
    assign o_player     = r_player;
    assign o_state      = r_state;
    assign o_busy       = w_busy;
    assign o_move_rej   = r_move_rej;

endmodule
`default_nettype wire

// File: tb/tb_move_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_commit_ctrl
// Brief    : Directed self-checking bench for move_commit_ctrl. Expected
//            checker hand-offs are queued when a place is driven and popped
//            when chk_req appears.
// Revision : 1.0  initial release
// ============================================================================
module tb_move_commit_ctrl;

    localparam int N = 225;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_place = 1'b0;
    logic       i_new_game = 1'b0;
    logic       i_chk_done = 1'b0;
    logic       i_chk_win = 1'b0;
    logic [7:0] i_cur_addr = '0;
    logic [7:0] i_rd_addr = '0;
    logic [1:0] o_rd_data;
    logic       o_chk_req;
    logic [7:0] o_chk_addr;
    logic       o_chk_player;
    logic       o_player;
    logic [1:0] o_state;
    logic       o_busy;
    logic       o_move_rej;
`ifdef UNDO_EN
    logic       i_undo = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr;
        logic       player;
    } exp_t;

    exp_t sb[$];
    logic m_player = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #10 clk = ~clk;

    move_commit_ctrl #(
        .BOARD_DIM (15),
        .ADDR_W    (8),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_place      (i_place),
        .i_new_game   (i_new_game),
`ifdef UNDO_EN
        .i_undo       (i_undo),
`endif
        .i_cur_addr   (i_cur_addr),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_chk_req    (o_chk_req),
        .o_chk_addr   (o_chk_addr),
        .o_chk_player (o_chk_player),
        .i_chk_done   (i_chk_done),
        .i_chk_win    (i_chk_win),
        .o_player     (o_player),
        .o_state      (o_state),
        .o_busy       (o_busy),
        .o_move_rej   (o_move_rej)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cell(input string tag, input logic [7:0] a, input logic [1:0] exp);
        i_rd_addr = a;
        #1;
        check(tag, {30'd0, o_rd_data}, {30'd0, exp});
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 1000) begin
            n++;
            tick();
        end
        check(tag, n, N);
    endtask

    // Full accepted move: place, expect chk_req at +3, verify hand-off, answer
    task automatic do_move(input logic [7:0] a, input logic win);
        int   n;
        exp_t e;
        sb.push_back('{addr: a, player: m_player});
        i_cur_addr = a;
        i_place = 1'b1;
        tick();
        i_place = 1'b0;
        n = 1;
        while (!o_chk_req && n < 20) begin
            tick();
            n++;
        end
        check("chk_latency", n, 3);
        e = sb.pop_front();
        check("chk_addr", {24'd0, o_chk_addr}, {24'd0, e.addr});
        check("chk_player", {31'd0, o_chk_player}, {31'd0, e.player});
        i_chk_done = 1'b1;
        i_chk_win = win;
        tick();
        i_chk_done = 1'b0;
        i_chk_win = 1'b0;
    endtask

    // Place that must be refused: move_rej at +2 and no checker request
    task automatic do_reject(input string tag, input logic [7:0] a);
        int   n;
        logic seen;
        i_cur_addr = a;
        i_place = 1'b1;
        tick();
        i_place = 1'b0;
        n = 1;
        while (!o_move_rej && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rej_latency"}, n, 2);
        seen = o_chk_req;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | o_chk_req | o_move_rej;
        end
        check({tag, "_no_req"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;

        // Reset values
        tick();
        tick();
        check("rst_chk_req", {31'd0, o_chk_req}, 32'd0);
        check("rst_chk_addr", {24'd0, o_chk_addr}, 32'd0);
        check("rst_chk_player", {31'd0, o_chk_player}, 32'd0);
        check("rst_player", {31'd0, o_player}, 32'd0);
        check("rst_state", {30'd0, o_state}, 32'd0);
        check("rst_move_rej", {31'd0, o_move_rej}, 32'd0);

        // Release: CLEAR runs exactly one cycle per cell
        reset_n = 1'b1;
        wait_clear("clear_after_reset");
        check_cell("cell0_empty", 8'd0, 2'b00);
        check_cell("cell112_empty", 8'd112, 2'b00);
        check_cell("cell224_empty", 8'd224, 2'b00);
        check("state_play", {30'd0, o_state}, 32'd0);
        check("player_black", {31'd0, o_player}, 32'd0);

        // Black at 112, not a win; stone must already be visible while checking
        sb.push_back('{addr: 8'd112, player: 1'b0});
        i_cur_addr = 8'd112;
        i_place = 1'b1;
        tick();
        i_place = 1'b0;
        n = 1;
        while (!o_chk_req && n < 20) begin
            tick();
            n++;
        end
        check("first_chk_latency", n, 3);
        begin
            exp_t e;
            e = sb.pop_front();
            check("first_chk_addr", {24'd0, o_chk_addr}, {24'd0, e.addr});
            check("first_chk_player", {31'd0, o_chk_player}, {31'd0, e.player});
        end
        check_cell("cell112_black", 8'd112, 2'b01);
        // chk_req held while the checker is slow
        tick();
        tick();
        check("chk_req_held", {31'd0, o_chk_req}, 32'd1);
        i_chk_done = 1'b1;
        tick();
        i_chk_done = 1'b0;
        m_player = 1'b1;
        check("player_after_move", {31'd0, o_player}, {31'd0, m_player});
        check("chk_req_dropped", {31'd0, o_chk_req}, 32'd0);

        // Occupied cell and out-of-range address are both refused
        do_reject("occupied", 8'd112);
        check("player_after_rej", {31'd0, o_player}, {31'd0, m_player});
        do_reject("out_of_range", 8'd230);
        check("player_after_oor", {31'd0, o_player}, {31'd0, m_player});

        // chk_done outside CHECK has no effect
        i_chk_done = 1'b1;
        i_chk_win = 1'b1;
        tick();
        i_chk_done = 1'b0;
        i_chk_win = 1'b0;
        tick();
        check("stray_done_state", {30'd0, o_state}, 32'd0);
        check("stray_done_player", {31'd0, o_player}, {31'd0, m_player});

        // White wins at 113
        do_move(8'd113, 1'b1);
        check("white_win_state", {30'd0, o_state}, 32'h2);
        check("white_win_player", {31'd0, o_player}, 32'd1);
        check_cell("cell113_white", 8'd113, 2'b10);

        // Game over: place ignored
        i_cur_addr = 8'd114;
        i_place = 1'b1;
        tick();
        i_place = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | o_chk_req | o_busy | o_move_rej;
            tick();
        end
        check("over_place_ignored", {31'd0, seen}, 32'd0);
        check_cell("cell114_empty", 8'd114, 2'b00);

        // new_game from OVER
        i_new_game = 1'b1;
        tick();
        i_new_game = 1'b0;
        m_player = 1'b0;
        wait_clear("clear_new_game");
        check("ng_state", {30'd0, o_state}, 32'd0);
        check("ng_player", {31'd0, o_player}, 32'd0);
        check_cell("ng_cell112", 8'd112, 2'b00);
        check_cell("ng_cell113", 8'd113, 2'b00);

`ifdef UNDO_EN
        // Commit at 5 then undo once; a second undo is spent
        do_move(8'd5, 1'b0);
        m_player = 1'b1;
        check("undo_pre_player", {31'd0, o_player}, 32'd1);
        i_undo = 1'b1;
        tick();
        i_undo = 1'b0;
        check("undo_busy", {31'd0, o_busy}, 32'd1);
        tick();
        m_player = 1'b0;
        check("undo_player", {31'd0, o_player}, 32'd0);
        check("undo_idle", {31'd0, o_busy}, 32'd0);
        check_cell("undo_cell5", 8'd5, 2'b00);
        i_undo = 1'b1;
        tick();
        i_undo = 1'b0;
        check("undo2_not_busy", {31'd0, o_busy}, 32'd0);
        tick();
        check("undo2_player", {31'd0, o_player}, 32'd0);
`endif

        // new_game during CHECK, with a simultaneous place that must lose
        i_cur_addr = 8'd7;
        i_place = 1'b1;
        tick();
        i_place = 1'b0;
        n = 1;
        while (!o_chk_req && n < 20) begin
            tick();
            n++;
        end
        check("ngchk_latency", n, 3);
        i_new_game = 1'b1;
        i_place = 1'b1;
        i_cur_addr = 8'd9;
        tick();
        i_new_game = 1'b0;
        i_place = 1'b0;
        m_player = 1'b0;
        check("ngchk_req_low", {31'd0, o_chk_req}, 32'd0);
        check("ngchk_busy", {31'd0, o_busy}, 32'd1);
        check("ngchk_player", {31'd0, o_player}, 32'd0);
        wait_clear("clear_ng_mid_check");
        check_cell("ngchk_cell7", 8'd7, 2'b00);
        check_cell("ngchk_cell9", 8'd9, 2'b00);

        // Fill the board with non-winning moves: draw after the last one
        for (int a = 0; a < N; a++) begin
            do_move(8'(a), 1'b0);
            if (a == N - 2) begin
                check("pre_draw_state", {30'd0, o_state}, 32'd0);
            end
            if (a != N - 1) begin
                m_player = ~m_player;
            end
        end
        check("draw_state", {30'd0, o_state}, 32'h3);
        check("draw_player", {31'd0, o_player}, {31'd0, m_player});
        check("draw_not_busy", {31'd0, o_busy}, 32'd0);
        check("sb_empty", sb.size(), 0);

        // Asynchronous reset while a check is pending
        i_new_game = 1'b1;
        tick();
        i_new_game = 1'b0;
        wait_clear("clear_before_async");
        i_cur_addr = 8'd20;
        i_place = 1'b1;
        tick();
        i_place = 1'b0;
        n = 1;
        while (!o_chk_req && n < 20) begin
            tick();
            n++;
        end
        check("async_latency", n, 3);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_chk_req", {31'd0, o_chk_req}, 32'd0);
        check("async_state", {30'd0, o_state}, 32'd0);
        tick();
        reset_n = 1'b1;
        wait_clear("clear_after_async");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
